// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: takes level commands over valid/ready and drives a
// registered button pin with LFSR-timed contact bounce before settling.
module bounce_gen #(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter int          SETTLE_MS   = 20,
  parameter int          NUM_BOUNCES = 4,
  parameter int          GLITCH_BITS = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic btn_out,
  output logic busy,
  output logic done
);

  localparam int SETTLE_CYCLES = (CLK_FREQ / 1000) * SETTLE_MS;
  localparam int SEG_TOTAL     = 2 * NUM_BOUNCES;
  localparam int IDX_W         = ($clog2(SEG_TOTAL + 1) < 1) ? 1 : $clog2(SEG_TOTAL + 1);
  localparam int SET_W         = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W         = GLITCH_BITS + 1;

  localparam logic [15:0]      SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(SEG_TOTAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // 16-bit Galois LFSR, right shift, taps 0xB400; nonzero states never reach 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t           state_q, state_nxt;
  logic             btn_q, btn_nxt;
  logic             done_q, done_nxt;
  logic             target_q, target_nxt;
  logic [IDX_W-1:0] n_seg_q, n_seg_nxt;
  logic [IDX_W-1:0] seg_idx_q, seg_idx_nxt;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_nxt;
  logic [SET_W-1:0] set_cnt_q, set_cnt_nxt;
  logic [15:0]      lfsr_q, lfsr_nxt;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign btn_out   = btn_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= IDLE_LEVEL;
      done_q    <= 1'b0;
      target_q  <= IDLE_LEVEL;
      n_seg_q   <= '0;
      seg_idx_q <= '0;
      seg_cnt_q <= '0;
      set_cnt_q <= '0;
      lfsr_q    <= SEED_EFF;
    end else begin
      btn_q     <= btn_nxt;
      done_q    <= done_nxt;
      target_q  <= target_nxt;
      n_seg_q   <= n_seg_nxt;
      seg_idx_q <= seg_idx_nxt;
      seg_cnt_q <= seg_cnt_nxt;
      set_cnt_q <= set_cnt_nxt;
      lfsr_q    <= lfsr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    btn_nxt     = btn_q;
    done_nxt    = 1'b0;
    target_nxt  = target_q;
    n_seg_nxt   = n_seg_q;
    seg_idx_nxt = seg_idx_q;
    seg_cnt_nxt = seg_cnt_q;
    set_cnt_nxt = set_cnt_q;
    lfsr_nxt    = lfsr_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // An unchanged level gets zero segments, so the pin settles on the next edge.
          target_nxt  = cmd_level;
          n_seg_nxt   = (cmd_level != btn_q) ? IDX_LAST : '0;
          seg_idx_nxt = '0;
          seg_cnt_nxt = '0;
          set_cnt_nxt = '0;
          state_nxt   = BOUNCE;
        end
      end

      BOUNCE: begin
        if (seg_cnt_q != '0) begin
          seg_cnt_nxt = seg_cnt_q - CNT_W'(1);
        end else if (seg_idx_q == n_seg_q) begin
          btn_nxt = target_q;
          if (SETTLE_CYCLES == 0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt   = SETTLE;
            set_cnt_nxt = '0;
          end
        end else begin
          // Load a segment: counter holds the remaining cycles after this edge.
          btn_nxt     = seg_idx_q[0] ? ~target_q : target_q;
          seg_cnt_nxt = {1'b0, lfsr_q[GLITCH_BITS-1:0]};
          lfsr_nxt    = lfsr_step(lfsr_q);
          seg_idx_nxt = seg_idx_q + IDX_W'(1);
        end
      end

      SETTLE: begin
        if (set_cnt_q == SETTLE_LAST) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          set_cnt_nxt = '0;
        end else begin
          set_cnt_nxt = set_cnt_q + SET_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
